id_ex_stage: RTL and testbench

Parametrised ID→EX pipeline stage register for the five-stage MIPS core. It replaces the fixed-width, always-loading ID/EX latch with one that supports stall (hold), flush (bubble insertion), per-entry valid tracking and asynchronous reset. It sits between the decode/register-read logic and the execute stage, and is driven by the hazard unit's stall and flush outputs.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/id_ex_stage_sat_counter.sv | 26 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, control-field bit positions and bubble constants.
package pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned EX_W   = 5;
  localparam int unsigned MEM_W  = 2;
  localparam int unsigned WB_W   = 2;

  // EX group: {RegDst, ALUSrc, ALUOp[2:0]}
  localparam int unsigned EX_REGDST    = 4;
  localparam int unsigned EX_ALUSRC    = 3;
  localparam int unsigned EX_ALUOP_MSB = 2;
  localparam int unsigned EX_ALUOP_LSB = 0;

  // MEM group: {MemRead, MemWrite}
  localparam int unsigned MEM_MEMREAD  = 1;
  localparam int unsigned MEM_MEMWRITE = 0;

  // WB group: {RegWrite, MemtoReg}
  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;

  localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;
  localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;
  localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decode-side *_d inputs and registered execute-side *_e outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_W  = pipe_pkg::REG_W,
  parameter int unsigned EX_W   = pipe_pkg::EX_W,
  parameter int unsigned MEM_W  = pipe_pkg::MEM_W,
  parameter int unsigned WB_W   = pipe_pkg::WB_W
);

  logic              valid_d;
  logic [EX_W-1:0]   ex_d;
  logic [MEM_W-1:0]  mem_d;
  logic [WB_W-1:0]   wb_d;
  logic [REG_W-1:0]  rs_d;
  logic [REG_W-1:0]  rt_d;
  logic [REG_W-1:0]  rd_d;
  logic [DATA_W-1:0] rd1_d;
  logic [DATA_W-1:0] rd2_d;
  logic [DATA_W-1:0] imm_d;

  logic              valid_e;
  logic [EX_W-1:0]   ex_e;
  logic [MEM_W-1:0]  mem_e;
  logic [WB_W-1:0]   wb_e;
  logic [REG_W-1:0]  rs_e;
  logic [REG_W-1:0]  rt_e;
  logic [REG_W-1:0]  rd_e;
  logic [DATA_W-1:0] rd1_e;
  logic [DATA_W-1:0] rd2_e;
  logic [DATA_W-1:0] imm_e;

  // Decode side drives *_d and observes *_e.
  modport master (
    output valid_d, ex_d, mem_d, wb_d, rs_d, rt_d, rd_d, rd1_d, rd2_d, imm_d,
    input  valid_e, ex_e, mem_e, wb_e, rs_e, rt_e, rd_e, rd1_e, rd2_e, imm_e
  );

  // Pipeline register consumes *_d and drives *_e.
  modport slave (
    input  valid_d, ex_d, mem_d, wb_d, rs_d, rt_d, rd_d, rd1_d, rd2_d, imm_d,
    output valid_e, ex_e, mem_e, wb_e, rs_e, rt_e, rd_e, rd1_e, rd2_e, imm_e
  );

endinterface

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with flush > stall > load priority and per-entry valid.
// Optional stall/bubble performance counters under PIPE_PERF_CNT_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W = pipe_pkg::DATA_W,
  parameter int unsigned REG_W  = pipe_pkg::REG_W,
  parameter int unsigned EX_W   = pipe_pkg::EX_W,
  parameter int unsigned MEM_W  = pipe_pkg::MEM_W,
  parameter int unsigned WB_W   = pipe_pkg::WB_W
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  id_ex_stage_if.slave      bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  import pipe_pkg::*;

  logic              r_valid;
  logic [EX_W-1:0]   r_ex;
  logic [MEM_W-1:0]  r_mem;
  logic [WB_W-1:0]   r_wb;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;

  // Flush wins over stall; an invalid decode slot loads as a control bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ex    <= EX_W'(EX_BUBBLE);
      r_mem   <= MEM_W'(MEM_BUBBLE);
      r_wb    <= WB_W'(WB_BUBBLE);
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
    end else if (!stall_i) begin
      r_valid <= bus.valid_d;
      r_ex    <= bus.valid_d ? bus.ex_d  : EX_W'(EX_BUBBLE);
      r_mem   <= bus.valid_d ? bus.mem_d : MEM_W'(MEM_BUBBLE);
      r_wb    <= bus.valid_d ? bus.wb_d  : WB_W'(WB_BUBBLE);
      r_rs    <= bus.rs_d;
      r_rt    <= bus.rt_d;
      r_rd    <= bus.rd_d;
      r_rd1   <= bus.rd1_d;
      r_rd2   <= bus.rd2_d;
      r_imm   <= bus.imm_d;
    end
  end

  assign bus.valid_e = r_valid;
  assign bus.ex_e    = r_ex;
  assign bus.mem_e   = r_mem;
  assign bus.wb_e    = r_wb;
  assign bus.rs_e    = r_rs;
  assign bus.rt_e    = r_rt;
  assign bus.rd_e    = r_rd;
  assign bus.rd1_e   = r_rd1;
  assign bus.rd2_e   = r_rd2;
  assign bus.imm_e   = r_imm;

`ifdef PIPE_PERF_CNT_EN
  logic w_hold;
  logic w_bubble;

  assign w_hold   = stall_i & ~flush_i;
  assign w_bubble = flush_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hold),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_bubble),
    .count (bubble_cnt_o)
  );
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage plus a standalone 2-bit sat_counter saturation check.
module tb_id_ex_stage;

  import pipe_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic stall_i = 1'b0;
  logic flush_i = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  id_ex_stage u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .bus          (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt)
`endif
  );

  logic       sat_inc = 1'b0;
  logic [1:0] sat_cnt;

  sat_counter #(.CNT_W(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sat_inc),
    .count (sat_cnt)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  ex;
    logic [1:0]  mem;
    logic [1:0]  wb;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [15:0] scnt;
    logic [15:0] bcnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_state(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(bus.valid_e), 64'(e.valid));
    chk({tag, ".ex"},    64'(bus.ex_e),    64'(e.ex));
    chk({tag, ".mem"},   64'(bus.mem_e),   64'(e.mem));
    chk({tag, ".wb"},    64'(bus.wb_e),    64'(e.wb));
    chk({tag, ".rs"},    64'(bus.rs_e),    64'(e.rs));
    chk({tag, ".rt"},    64'(bus.rt_e),    64'(e.rt));
    chk({tag, ".rd"},    64'(bus.rd_e),    64'(e.rd));
    chk({tag, ".rd1"},   64'(bus.rd1_e),   64'(e.rd1));
    chk({tag, ".rd2"},   64'(bus.rd2_e),   64'(e.rd2));
    chk({tag, ".imm"},   64'(bus.imm_e),   64'(e.imm));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, ".scnt"},  64'(stall_cnt),   64'(e.scnt));
    chk({tag, ".bcnt"},  64'(bubble_cnt),  64'(e.bcnt));
`endif
  endtask

  function automatic exp_t zero_data(input exp_t e);
    exp_t r = e;
    r.valid = 1'b0; r.ex = '0; r.mem = '0; r.wb = '0;
    r.rs = '0; r.rt = '0; r.rd = '0; r.rd1 = '0; r.rd2 = '0; r.imm = '0;
    return r;
  endfunction

  // One clock: drive at negedge, predict, push; pop and compare just after the rising edge.
  task automatic step(input string tag, input logic st, input logic fl, input logic v,
                      input logic [4:0] ex, input logic [1:0] mem, input logic [1:0] wb,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
    exp_t e;
    @(negedge clk);
    stall_i = st; flush_i = fl;
    bus.valid_d = v; bus.ex_d = ex; bus.mem_d = mem; bus.wb_d = wb;
    bus.rs_d = rs; bus.rt_d = rt; bus.rd_d = rd;
    bus.rd1_d = rd1; bus.rd2_d = rd2; bus.imm_d = imm;
    if (fl) begin
      m = zero_data(m);
      if (m.bcnt != 16'hFFFF) m.bcnt = m.bcnt + 16'd1;
    end else if (st) begin
      if (m.scnt != 16'hFFFF) m.scnt = m.scnt + 16'd1;
    end else begin
      m.valid = v;
      m.ex  = v ? ex  : 5'd0;
      m.mem = v ? mem : 2'd0;
      m.wb  = v ? wb  : 2'd0;
      m.rs = rs; m.rt = rt; m.rd = rd;
      m.rd1 = rd1; m.rd2 = rd2; m.imm = imm;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      cmp_state(tag, e);
    end
  endtask

  // Assert reset between edges and check it clears without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m = zero_data(m);
    m.scnt = '0;
    m.bcnt = '0;
    sb.delete();
    cmp_state(tag, m);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    logic [15:0] s0;
    logic [15:0] b0;
    bus.valid_d = 1'b0; bus.ex_d = '0; bus.mem_d = '0; bus.wb_d = '0;
    bus.rs_d = '0; bus.rt_d = '0; bus.rd_d = '0;
    bus.rd1_d = '0; bus.rd2_d = '0; bus.imm_d = '0;
    m = zero_data(m);
    m.scnt = '0;
    m.bcnt = '0;

    #3;
    cmp_state("por", m);
    @(negedge clk);
    rst_n = 1'b1;

    step("pre_rst", 0, 0, 1, 5'h0A, 2'b01, 2'b10, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33);
    async_reset("async_rst");
    step("first_load", 0, 0, 1, 5'h1F, 2'b00, 2'b10, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    chk("first_load.ex_1f", 64'(bus.ex_e), 64'h1F);
    chk("first_load.rd1", 64'(bus.rd1_e), 64'hDEADBEEF);

    s0 = m.scnt;
    step("stall_ld", 0, 0, 1, 5'h03, 2'b00, 2'b10, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1, 0, 1, 5'h07, 2'b01, 2'b11, 5'd7, 5'd8, 5'd9, 32'h7, 32'h8, 32'h9);
      chk("stall_hold.rs3", 64'(bus.rs_e), 64'd3);
    end
    step("stall_rel", 0, 0, 1, 5'h07, 2'b01, 2'b11, 5'd7, 5'd8, 5'd9, 32'h7, 32'h8, 32'h9);
    chk("stall_rel.rs7", 64'(bus.rs_e), 64'd7);
    chk("stall_cnt_delta", 64'(m.scnt - s0), 64'd3);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt_abs", 64'(stall_cnt), 64'(s0 + 16'd3));
`endif

    s0 = m.scnt;
    b0 = m.bcnt;
    step("flush_stall", 1, 1, 1, 5'h1F, 2'b11, 2'b11, 5'd9, 5'd9, 5'd9, 32'hAA, 32'hBB, 32'hCC);
    chk("flush_stall.wb0", 64'(bus.wb_e), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("flush_stall.bcnt", 64'(bubble_cnt), 64'(b0 + 16'd1));
    chk("flush_stall.scnt", 64'(stall_cnt), 64'(s0));
`endif

    step("invalid", 0, 0, 0, 5'h15, 2'b10, 2'b01, 5'd1, 5'd2, 5'd3, 32'h44, 32'h55, 32'h66);
    chk("invalid.mem0", 64'(bus.mem_e), 64'd0);
    chk("invalid.rd2", 64'(bus.rd2_e), 64'h55);

    for (int i = 0; i < 4; i++) begin
      step("b2b", 0, 0, 1, 5'(i + 1), 2'(i), 2'(3 - i), 5'(i + 10), 5'(i + 20), 5'(i + 30),
           32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h3000 + 32'(i));
      chk("b2b.seq", 64'(bus.rd1_e), 64'(32'h1000 + 32'(i)));
    end

    for (int i = 0; i < 3; i++)
      step("flush_n", 0, 1, 1, 5'h1F, 2'b11, 2'b11, 5'd1, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1);

    step("rst_stall_ld", 0, 0, 1, 5'h0C, 2'b01, 2'b11, 5'd6, 5'd7, 5'd8, 32'hCAFE, 32'hF00D, 32'hBEEF);
    step("rst_stall_h", 1, 0, 1, 5'h01, 2'b10, 2'b01, 5'd1, 5'd2, 5'd3, 32'h9, 32'h9, 32'h9);
    async_reset("rst_in_stall");
    step("rst_fresh", 0, 0, 1, 5'h02, 2'b10, 2'b01, 5'd11, 5'd12, 5'd13, 32'h77, 32'h88, 32'h99);

    for (int i = 0; i < 60; i++) begin
      step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 4) != 0), 5'($urandom), 2'($urandom), 2'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    end

    @(negedge clk);
    stall_i = 1'b0;
    flush_i = 1'b0;
    chk("sat_init", 64'(sat_cnt), 64'd0);
    sat_inc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("sat_seq", 64'(sat_cnt), 64'(sat_exp[i]));
    end
    sat_inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
